// File: rtl/wtm_accum_if.sv
// -----------------------------------------------------------------------------
// wtm_accum_if
//   Bundles the handshake and data signals of the wtm_accum block.
//   master : the side that issues start and products and consumes results
//   slave  : the accumulator itself
// Signals
//   start      1      one-cycle run request (master -> slave)
//   prod       16     unsigned product from the Wallace tree multiplier
//   in_valid   1      prod valid this cycle
//   in_ready   1      accumulator accepts prod this cycle
//   acc        ACC_W  accumulated result
//   out_valid  1      result available
//   out_ready  1      consumer takes result
//   busy       1      run in progress (ACCUM or DONE)
//   ovf        1      sticky overflow flag for the current/last run
// -----------------------------------------------------------------------------
interface wtm_accum_if #(
  parameter int ACC_W = 24
) ();
  logic             start;
  logic [15:0]      prod;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] acc;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             ovf;

  modport master (
    output start, prod, in_valid, out_ready,
    input  in_ready, acc, out_valid, busy, ovf
  );

  modport slave (
    input  start, prod, in_valid, out_ready,
    output in_ready, acc, out_valid, busy, ovf
  );
endinterface

// File: rtl/wtm_accum.sv
// -----------------------------------------------------------------------------
// wtm_accum
//   Sequential accumulator placed after the 8x8 Wallace tree multiplier.
//   A start pulse in IDLE clears the accumulator and opens a run; the next LEN
//   accepted 16-bit unsigned products are summed into an ACC_W-bit result,
//   which is then presented with out_valid until the consumer takes it.
// Parameters
//   ACC_W  accumulator / result width (>= 16)
//   LEN    products summed per run (>= 1)
// Ports
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   bus    wtm_accum_if.slave: start, prod/in_valid/in_ready,
//          acc/out_valid/out_ready, busy, ovf
// Configuration
//   WTM_ACC_SAT_EN  when defined, an overflowing run clamps acc to all ones
//                   for the remainder of the run; otherwise acc wraps.
//                   ovf is set on overflow in both builds.
// -----------------------------------------------------------------------------
module wtm_accum #(
  parameter int ACC_W = 24,
  parameter int LEN   = 8
) (
  input  logic        clk,
  input  logic        rst,
  wtm_accum_if.slave  bus
);

  localparam int CNT_W = (LEN < 1) ? 1 : $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
  localparam int PAD_W = ACC_W + 1 - 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q,   acc_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             ovf_q,   ovf_d;
  logic             busy_q,  busy_d;

  logic [ACC_W:0]   sum_w;
  logic             accept_w;

  // Full-width sum: the extra top bit is the carry out of the accumulator.
  function automatic logic [ACC_W:0] add_prod(input logic [ACC_W-1:0] a,
                                              input logic [15:0]      p);
    return {1'b0, a} + {{PAD_W{1'b0}}, p};
  endfunction

  // Result of one accumulation step. A carry either wraps or clamps. Once
  // clamped at all ones, any further non-zero product carries again, so the
  // value stays clamped for the rest of the run without extra state.
  function automatic logic [ACC_W-1:0] wrap_or_sat(input logic [ACC_W:0] s);
`ifdef WTM_ACC_SAT_EN
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
    return s[ACC_W-1:0];
`endif
  endfunction

  assign sum_w    = add_prod(acc_q, bus.prod);
  assign accept_w = (state_q == ST_ACCUM) && bus.in_valid;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept_w) begin
          acc_d = wrap_or_sat(sum_w);
          ovf_d = ovf_q | sum_w[ACC_W];
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // acc is held; start is deliberately ignored here.
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // busy is registered alongside state so it lines up with it exactly.
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_ACCUM);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.acc       = acc_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_wtm_accum.sv
module tb_wtm_accum;

`ifdef WTM_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wtm_accum_if #(.ACC_W(24)) ifa ();
  wtm_accum_if #(.ACC_W(16)) ifb ();

  wtm_accum #(.ACC_W(24), .LEN(8)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  wtm_accum #(.ACC_W(16), .LEN(2)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  // Shared stimulus, steered to the DUT selected by sel; the other sees zeros.
  int          sel = 0;
  logic        start_r = 0, in_valid_r = 0, out_ready_r = 0;
  logic [15:0] prod_r = 0;

  assign ifa.start     = (sel == 0) ? start_r     : 1'b0;
  assign ifa.in_valid  = (sel == 0) ? in_valid_r  : 1'b0;
  assign ifa.out_ready = (sel == 0) ? out_ready_r : 1'b0;
  assign ifa.prod      = (sel == 0) ? prod_r      : 16'h0;
  assign ifb.start     = (sel == 1) ? start_r     : 1'b0;
  assign ifb.in_valid  = (sel == 1) ? in_valid_r  : 1'b0;
  assign ifb.out_ready = (sel == 1) ? out_ready_r : 1'b0;
  assign ifb.prod      = (sel == 1) ? prod_r      : 16'h0;

  logic [63:0] got_acc;
  logic        got_ov, got_ir, got_bz, got_ovf;
  always_comb begin
    got_acc = (sel == 1) ? {48'h0, ifb.acc}  : {40'h0, ifa.acc};
    got_ov  = (sel == 1) ? ifb.out_valid     : ifa.out_valid;
    got_ir  = (sel == 1) ? ifb.in_ready      : ifa.in_ready;
    got_bz  = (sel == 1) ? ifb.busy          : ifa.busy;
    got_ovf = (sel == 1) ? ifb.ovf           : ifa.ovf;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: the result of a run is the plain integer sum of its products,
  // reduced to the accumulator width by wrapping or clamping.
  logic [15:0] pv[8];
  logic [63:0] exp_acc;
  logic        exp_ovf;

  task automatic model(input int len, input int w);
    longint unsigned total = 0;
    longint unsigned maxv  = (64'd1 << w) - 1;
    for (int i = 0; i < len; i++) total += pv[i];
    exp_ovf = (total > maxv);
    if (SAT) exp_acc = exp_ovf ? maxv : total;
    else     exp_acc = total & maxv;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_acc"},  got_acc, 64'd0);
    check({tag, "_ov"},   {63'd0, got_ov},  64'd0);
    check({tag, "_ir"},   {63'd0, got_ir},  64'd0);
    check({tag, "_busy"}, {63'd0, got_bz},  64'd0);
    check({tag, "_ovf"},  {63'd0, got_ovf}, 64'd0);
  endtask

  // mode: 0 back-to-back, 1 in_valid every other cycle, 2 random bubbles.
  // hold: cycles of out_ready=0 in DONE with in_valid=1 and start=1 driven.
  task automatic run(input int s, input int len, input int w, input int mode, input int hold);
    int k = 0;
    int cyc = 0;
    logic v;
    sel = s;
    model(len, w);
    start_r = 1'b1;
    step();
    start_r = 1'b0;
    check("start_busy", {63'd0, got_bz}, 64'd1);
    while (k < len && cyc < 500) begin
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = (cyc % 2 == 0);
      else                v = 1'($urandom_range(0, 1));
      in_valid_r = v;
      prod_r     = v ? pv[k] : 16'($urandom);
      check("accum_in_ready",  {63'd0, got_ir}, 64'd1);
      check("accum_out_valid", {63'd0, got_ov}, 64'd0);
      step();
      cyc++;
      if (v) k++;
    end
    if (k < len) check("accept_timeout", 64'(k), 64'(len));
    in_valid_r = 1'b0;
    // Sampled one cycle after the last accept.
    check("done_out_valid", {63'd0, got_ov},  64'd1);
    check("done_in_ready",  {63'd0, got_ir},  64'd0);
    check("done_busy",      {63'd0, got_bz},  64'd1);
    check("done_acc",       got_acc,          exp_acc);
    check("done_ovf",       {63'd0, got_ovf}, {63'd0, exp_ovf});
    in_valid_r = 1'b1;
    start_r    = 1'b1;
    for (int i = 0; i < hold; i++) begin
      prod_r = 16'($urandom);
      step();
      check("hold_out_valid", {63'd0, got_ov}, 64'd1);
      check("hold_in_ready",  {63'd0, got_ir}, 64'd0);
      check("hold_acc",       got_acc,         exp_acc);
    end
    // start stays high in the handoff cycle and must not open a new run.
    out_ready_r = 1'b1;
    step();
    out_ready_r = 1'b0;
    start_r     = 1'b0;
    in_valid_r  = 1'b0;
    check("handoff_out_valid", {63'd0, got_ov}, 64'd0);
    check("handoff_busy",      {63'd0, got_bz}, 64'd0);
    check("handoff_in_ready",  {63'd0, got_ir}, 64'd0);
    check("handoff_acc_kept",  got_acc,         exp_acc);
    step();
    check("idle_busy", {63'd0, got_bz}, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    sel = 0; #0; check_idle_zero("por_a");
    sel = 1; #0; check_idle_zero("por_b");

    // Back-to-back run of 255*255 products
    for (int i = 0; i < 8; i++) pv[i] = 16'hFE01;
    run(0, 8, 24, 0, 0);
    check("b2b_const_acc", got_acc, 64'h07F008);

    // Bubbles every other cycle, prod = 1..8
    for (int i = 0; i < 8; i++) pv[i] = 16'(i + 1);
    run(0, 8, 24, 1, 0);
    check("bubble_const_acc", got_acc, 64'd36);

    // Output backpressure for 10 cycles
    for (int i = 0; i < 8; i++) pv[i] = 16'($urandom);
    run(0, 8, 24, 2, 10);

    // Reset while idle, after a completed run (acc non-zero before)
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check_idle_zero("idle_rst");

    // Reset mid-run after 3 of 8 accepts
    sel = 0;
    start_r = 1'b1;
    step();
    start_r = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid_r = 1'b1;
      prod_r     = 16'h1234;
      step();
    end
    in_valid_r = 1'b0;
    check("midrun_busy", {63'd0, got_bz}, 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_zero("midrun_rst");
    for (int i = 0; i < 8; i++) pv[i] = 16'd2;
    run(0, 8, 24, 0, 0);
    check("after_rst_acc", got_acc, 64'd16);
    check("after_rst_ovf", {63'd0, got_ovf}, 64'd0);

    // Overflow on the narrow instance: 0xFFFF + 0x0002
    pv[0] = 16'hFFFF;
    pv[1] = 16'h0002;
    run(1, 2, 16, 0, 0);
    check("ovf_flag", {63'd0, got_ovf}, 64'd1);

    // A clean run afterwards clears ovf at start
    pv[0] = 16'h0010;
    pv[1] = 16'h0020;
    run(1, 2, 16, 0, 0);
    check("ovf_cleared", {63'd0, got_ovf}, 64'd0);

    // Randomized runs on both instances
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 8; i++) pv[i] = 16'($urandom);
      if (r % 2 == 0) run(0, 8, 24, 2, int'($urandom_range(0, 3)));
      else            run(1, 2, 16, 2, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
